// File: rtl/mul_pkg.sv
// Shared definitions for the Booth multiplier sequencer.
//   - Default operand / accumulator / watchdog sizes.
//   - Sequencer state encoding (2-bit, kept as plain constants so the
//     encoding stays stable for older blocks that decode it directly).
package mul_pkg;

  localparam int unsigned DefW       = 8;
  localparam int unsigned DefAccW    = 2 * DefW + 8;
  localparam int unsigned DefTimeout = 4 * DefW + 8;

  typedef logic [1:0] state_t;

  localparam state_t IDLE  = 2'd0;
  localparam state_t START = 2'd1;
  localparam state_t WAIT  = 2'd2;
  localparam state_t OUT   = 2'd3;

endpackage

// File: rtl/mul_sequencer_if.sv
// Bus bundle between the multiplier sequencer and its environment.
//   Upstream   : InValid/InReady handshake carrying InM, InQ, InAcc.
//   Multiplier : Start, M, Q, MulReset out; MulDone, P back.
//   Downstream : OutValid/OutReady handshake carrying OutData, plus Ovf, Err.
// Modports:
//   master - the sequencer's view (drives Start, M/Q, results).
//   slave  - the surrounding logic (producer, multiplier, consumer).
interface mul_sequencer_if #(
  parameter int unsigned W    = 8,
  parameter int unsigned ACCW = 2 * W + 8
) ();

  logic            InValid;
  logic            InReady;
  logic [W-1:0]    InM;
  logic [W-1:0]    InQ;
  logic            InAcc;
  logic            Start;
  logic [W-1:0]    M;
  logic [W-1:0]    Q;
  logic            MulReset;
  logic            MulDone;
  logic [2*W-1:0]  P;
  logic            OutValid;
  logic            OutReady;
  logic [ACCW-1:0] OutData;
  logic            Ovf;
  logic            Err;

  modport master (
    input  InValid, InM, InQ, InAcc, MulDone, P, OutReady,
    output InReady, Start, M, Q, MulReset, OutValid, OutData, Ovf, Err
  );

  modport slave (
    output InValid, InM, InQ, InAcc, MulDone, P, OutReady,
    input  InReady, Start, M, Q, MulReset, OutValid, OutData, Ovf, Err
  );

endinterface

// File: rtl/mul_watchdog.sv
// Cycle watchdog for the multiplier wait phase.
//   Clock, Reset : clock, synchronous active-high reset.
//   clear_i      : zero the counter (takes priority over enable_i).
//   enable_i     : count one cycle.
//   expire_o     : high while enabled and TIMEOUT-1 cycles have already
//                  been counted, i.e. on the TIMEOUT-th enabled cycle.
module mul_watchdog #(
  parameter int unsigned TIMEOUT = 40
) (
  input  logic Clock,
  input  logic Reset,
  input  logic clear_i,
  input  logic enable_i,
  output logic expire_o
);

  localparam int unsigned CntW = $clog2(TIMEOUT + 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (enable_i && (cnt_q != CntW'(TIMEOUT))) begin
      // Saturate so a stalled enable can never wrap back into range.
      cnt_d = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire_o = enable_i && (cnt_q == CntW'(TIMEOUT - 1));

endmodule

// File: rtl/mul_sequencer.sv
// Operand sequencer and product collector around a W-bit sequential Booth
// multiplier. Accepts one signed operand pair, holds it on M/Q while the
// multiplier runs, captures P on MulDone, optionally accumulates it, and
// offers the accumulator downstream. A watchdog resets the multiplier and
// sets a sticky Err if MulDone never arrives.
//   Clock, Reset : clock, synchronous active-high reset.
//   bus          : mul_sequencer_if master view (upstream handshake,
//                  multiplier controls, downstream handshake, Ovf, Err).
// ACCW must be at least 2*W.
module mul_sequencer
  import mul_pkg::*;
#(
  parameter int unsigned W       = DefW,
  parameter int unsigned ACCW    = 2 * W + 8,
  parameter int unsigned TIMEOUT = 4 * W + 8
) (
  input  logic            Clock,
  input  logic            Reset,
  mul_sequencer_if.master bus
);

  state_t          state_q, state_d;
  logic [W-1:0]    m_q, m_d;
  logic [W-1:0]    q_q, q_d;
  logic            acc_mode_q, acc_mode_d;
  logic [ACCW-1:0] acc_q, acc_d;
  logic            ovf_q, ovf_d;
  logic            err_q, err_d;
  logic            mul_rst_q, mul_rst_d;

  logic            wd_expire;
  logic [ACCW-1:0] sp;
  logic [ACCW-1:0] sum;
  logic            add_ovf;

  mul_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .Clock    (Clock),
    .Reset    (Reset),
    .clear_i  (state_q == START),
    .enable_i (state_q == WAIT),
    .expire_o (wd_expire)
  );

  assign sp  = ACCW'($signed(bus.P));
  assign sum = acc_q + sp;
  // Two's complement overflow: like-signed addends give an unlike-signed sum.
  assign add_ovf = (acc_q[ACCW-1] == sp[ACCW-1]) && (sum[ACCW-1] != acc_q[ACCW-1]);

  always_comb begin
    state_d    = state_q;
    m_d        = m_q;
    q_d        = q_q;
    acc_mode_d = acc_mode_q;
    acc_d      = acc_q;
    ovf_d      = ovf_q;
    err_d      = err_q;
    mul_rst_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.InValid) begin
          m_d        = bus.InM;
          q_d        = bus.InQ;
          acc_mode_d = bus.InAcc;
          state_d    = START;
        end
      end
      START: begin
        state_d = WAIT;
      end
      WAIT: begin
        // MulDone outranks a coincident watchdog expiry.
        if (bus.MulDone) begin
          if (acc_mode_q) begin
            acc_d = sum;
            ovf_d = ovf_q | add_ovf;
          end else begin
            acc_d = sp;
            ovf_d = 1'b0;
          end
          state_d = OUT;
        end else if (wd_expire) begin
          err_d     = 1'b1;
          mul_rst_d = 1'b1;
          state_d   = IDLE;
        end
      end
      OUT: begin
        if (bus.OutReady) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q    <= IDLE;
      m_q        <= '0;
      q_q        <= '0;
      acc_mode_q <= 1'b0;
      acc_q      <= '0;
      ovf_q      <= 1'b0;
      err_q      <= 1'b0;
      mul_rst_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      m_q        <= m_d;
      q_q        <= q_d;
      acc_mode_q <= acc_mode_d;
      acc_q      <= acc_d;
      ovf_q      <= ovf_d;
      err_q      <= err_d;
      mul_rst_q  <= mul_rst_d;
    end
  end

  assign bus.InReady  = (state_q == IDLE);
  assign bus.Start    = (state_q == START);
  assign bus.OutValid = (state_q == OUT);
  assign bus.M        = m_q;
  assign bus.Q        = q_q;
  assign bus.OutData  = acc_q;
  assign bus.Ovf      = ovf_q;
  assign bus.Err      = err_q;
  // Multiplier is held in reset with us, and pulsed once on a watchdog trip.
  assign bus.MulReset = Reset | mul_rst_q;

endmodule

// File: tb/tb_mul_sequencer.sv
// Self-checking bench for mul_sequencer. Two instances (ACCW=24 and ACCW=16)
// run in lockstep on identical stimulus; a behavioural multiplier answers
// Start with MulDone after a programmable latency.
module tb_mul_sequencer;

  localparam int unsigned W = 8;

  logic        Clock;
  logic        Reset;
  logic        in_valid;
  logic [7:0]  in_m;
  logic [7:0]  in_q;
  logic        in_acc;
  logic        out_ready;
  logic        mul_done;
  logic [15:0] mul_p;

  mul_sequencer_if #(.W(W), .ACCW(24)) bus_a ();
  mul_sequencer_if #(.W(W), .ACCW(16)) bus_b ();

  assign bus_a.InValid  = in_valid;
  assign bus_a.InM      = in_m;
  assign bus_a.InQ      = in_q;
  assign bus_a.InAcc    = in_acc;
  assign bus_a.OutReady = out_ready;
  assign bus_a.MulDone  = mul_done;
  assign bus_a.P        = mul_p;
  assign bus_b.InValid  = in_valid;
  assign bus_b.InM      = in_m;
  assign bus_b.InQ      = in_q;
  assign bus_b.InAcc    = in_acc;
  assign bus_b.OutReady = out_ready;
  assign bus_b.MulDone  = mul_done;
  assign bus_b.P        = mul_p;

  mul_sequencer #(.W(W), .ACCW(24), .TIMEOUT(40)) dut_a (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (bus_a)
  );

  mul_sequencer #(.W(W), .ACCW(16), .TIMEOUT(40)) dut_b (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (bus_b)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  int passed = 0;
  int total  = 0;

  task automatic chk(input string name, input longint got, input longint exp);
    total++;
    if (got == exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d", name, got, exp);
  endtask

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  // Behavioural multiplier.
  int mul_lat = 3;
  bit mul_en  = 1'b1;

  initial begin : mul_model
    int cnt;
    int lm;
    int lq;
    bit busy;
    busy     = 1'b0;
    cnt      = 0;
    lm       = 0;
    lq       = 0;
    mul_done = 1'b0;
    mul_p    = '0;
    forever begin
      @(posedge Clock);
      #2;
      mul_done = 1'b0;
      if (busy) begin
        cnt--;
        if (cnt == 0) begin
          mul_done = 1'b1;
          mul_p    = 16'(lm * lq);
          busy     = 1'b0;
        end
      end else if (bus_a.Start && mul_en) begin
        busy = 1'b1;
        cnt  = mul_lat;
        lm   = int'($signed(bus_a.M));
        lq   = int'($signed(bus_a.Q));
      end
    end
  end

  // Reference accumulator: plain integer arithmetic, wrapped to the width.
  longint macc [2];
  bit     movf [2];
  bit     merr;
  int     accw [2] = '{24, 16};

  function automatic longint wrap(input longint v, input int bits);
    longint md;
    longint r;
    md = longint'(1) << bits;
    r  = v % md;
    if (r < 0) r += md;
    if (r >= md / 2) r -= md;
    return r;
  endfunction

  task automatic model_apply(input int m, input int q, input bit acc);
    longint prod;
    longint s;
    prod = longint'(m) * longint'(q);
    for (int i = 0; i < 2; i++) begin
      if (acc) begin
        s = macc[i] + prod;
        if (wrap(s, accw[i]) != s) movf[i] = 1'b1;
        macc[i] = wrap(s, accw[i]);
      end else begin
        macc[i] = wrap(prod, accw[i]);
        movf[i] = 1'b0;
      end
    end
  endtask

  task automatic cmp_model(input string name);
    chk({name, "_data24"}, longint'($signed(bus_a.OutData)), macc[0]);
    chk({name, "_ovf24"}, longint'(bus_a.Ovf), longint'(movf[0]));
    chk({name, "_data16"}, longint'($signed(bus_b.OutData)), macc[1]);
    chk({name, "_ovf16"}, longint'(bus_b.Ovf), longint'(movf[1]));
    chk({name, "_err"}, longint'(bus_a.Err), longint'(merr));
  endtask

  task automatic send(input int m, input int q, input bit acc);
    in_m     = 8'(m);
    in_q     = 8'(q);
    in_acc   = acc;
    in_valid = 1'b1;
    for (int i = 0; i < 200 && !bus_a.InReady; i++) step();
    chk("in_ready_wait", longint'(bus_a.InReady), 1);
    step();
    in_valid = 1'b0;
    chk("start_pulse", longint'(bus_a.Start), 1);
    step();
    chk("start_once", longint'(bus_a.Start), 0);
  endtask

  task automatic wait_out(input int m, input int q);
    bit stable;
    stable = 1'b1;
    for (int i = 0; i < 200 && !bus_a.OutValid; i++) begin
      if (bus_a.M != 8'(m) || bus_a.Q != 8'(q)) stable = 1'b0;
      step();
    end
    chk("out_valid_wait", longint'(bus_a.OutValid), 1);
    chk("mq_stable", longint'(stable), 1);
  endtask

  task automatic take();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("out_drop", longint'(bus_a.OutValid), 0);
    chk("in_ready_back", longint'(bus_a.InReady), 1);
  endtask

  task automatic do_op(input int m, input int q, input bit acc, input int hold, input string name);
    send(m, q, acc);
    wait_out(m, q);
    for (int i = 0; i < hold; i++) step();
    model_apply(m, q, acc);
    cmp_model(name);
    take();
  endtask

  typedef struct {
    int     m;
    int     q;
    bit     acc;
    longint exp_a;
    bit     ovf_a;
    longint exp_b;
    bit     ovf_b;
  } vec_t;

  vec_t vecs [6];

  initial begin : global_timeout
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin : main
    longint d_a;
    bit     ok;
    bit     seen;

    vecs[0] = '{7, -8, 1'b0, -56, 1'b0, -56, 1'b0};
    vecs[1] = '{7, -6, 1'b0, -42, 1'b0, -42, 1'b0};
    vecs[2] = '{13, -10, 1'b1, -172, 1'b0, -172, 1'b0};
    vecs[3] = '{-128, -128, 1'b0, 16384, 1'b0, 16384, 1'b0};
    vecs[4] = '{-128, -128, 1'b1, 32768, 1'b0, -32768, 1'b1};
    vecs[5] = '{1, 1, 1'b0, 1, 1'b0, 1, 1'b0};

    Reset     = 1'b1;
    in_valid  = 1'b0;
    in_m      = '0;
    in_q      = '0;
    in_acc    = 1'b0;
    out_ready = 1'b0;
    macc      = '{0, 0};
    movf      = '{1'b0, 1'b0};
    merr      = 1'b0;

    // Reset state.
    repeat (3) step();
    chk("rst_mulreset", longint'(bus_a.MulReset), 1);
    chk("rst_outvalid", longint'(bus_a.OutValid), 0);
    chk("rst_start", longint'(bus_a.Start), 0);
    Reset = 1'b0;
    step();
    chk("idle_mulreset", longint'(bus_a.MulReset), 0);
    chk("idle_inready", longint'(bus_a.InReady), 1);
    chk("idle_m", longint'(bus_a.M), 0);
    chk("idle_q", longint'(bus_a.Q), 0);
    chk("idle_data", longint'(bus_a.OutData), 0);
    chk("idle_ovf", longint'(bus_a.Ovf), 0);
    chk("idle_err", longint'(bus_a.Err), 0);

    // Directed vectors.
    for (int i = 0; i < 6; i++) begin
      send(vecs[i].m, vecs[i].q, vecs[i].acc);
      wait_out(vecs[i].m, vecs[i].q);
      model_apply(vecs[i].m, vecs[i].q, vecs[i].acc);
      chk($sformatf("vec%0d_data24", i), longint'($signed(bus_a.OutData)), vecs[i].exp_a);
      chk($sformatf("vec%0d_ovf24", i), longint'(bus_a.Ovf), longint'(vecs[i].ovf_a));
      chk($sformatf("vec%0d_data16", i), longint'($signed(bus_b.OutData)), vecs[i].exp_b);
      chk($sformatf("vec%0d_ovf16", i), longint'(bus_b.Ovf), longint'(vecs[i].ovf_b));
      chk($sformatf("vec%0d_err", i), longint'(bus_a.Err), 0);
      take();
    end

    // Backpressure with a pre-offered next operand.
    send(5, -3, 1'b0);
    wait_out(5, -3);
    model_apply(5, -3, 1'b0);
    cmp_model("bp_first");
    d_a      = longint'($signed(bus_a.OutData));
    in_m     = 8'd2;
    in_q     = 8'd2;
    in_acc   = 1'b0;
    in_valid = 1'b1;
    ok       = 1'b1;
    repeat (10) begin
      step();
      if (longint'($signed(bus_a.OutData)) != d_a || bus_a.InReady || !bus_a.OutValid) ok = 1'b0;
    end
    chk("bp_hold", longint'(ok), 1);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("bp_no_early_start", longint'(bus_a.Start), 0);
    chk("bp_ready_after", longint'(bus_a.InReady), 1);
    step();
    chk("bp_accept", longint'(bus_a.Start), 1);
    in_valid = 1'b0;
    step();
    wait_out(2, 2);
    model_apply(2, 2, 1'b0);
    cmp_model("bp_second");
    take();

    // MulDone on the very cycle the watchdog would fire.
    mul_lat = 40;
    do_op(2, -3, 1'b0, 0, "done_at_expiry");

    // Watchdog trip.
    mul_en = 1'b0;
    send(6, 6, 1'b0);
    repeat (39) step();
    chk("wd_not_early_err", longint'(bus_a.Err), 0);
    chk("wd_not_early_ready", longint'(bus_a.InReady), 0);
    step();
    merr = 1'b1;
    chk("wd_err", longint'(bus_a.Err), 1);
    chk("wd_mulreset", longint'(bus_a.MulReset), 1);
    chk("wd_inready", longint'(bus_a.InReady), 1);
    chk("wd_no_out", longint'(bus_a.OutValid), 0);
    step();
    chk("wd_mulreset_pulse", longint'(bus_a.MulReset), 0);
    mul_en  = 1'b1;
    mul_lat = 3;
    do_op(3, 5, 1'b0, 0, "after_wd");

    // Randomized operations against the reference model.
    for (int n = 0; n < 40; n++) begin
      int rm;
      int rq;
      rm      = int'($urandom_range(0, 255)) - 128;
      rq      = int'($urandom_range(0, 255)) - 128;
      mul_lat = int'($urandom_range(1, 10));
      do_op(rm, rq, 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)), $sformatf("rnd%0d", n));
    end

    // Reset five cycles after Start; the late MulDone must be ignored.
    mul_lat = 12;
    send(9, 9, 1'b0);
    repeat (4) step();
    Reset = 1'b1;
    #1;
    chk("midrst_mulreset", longint'(bus_a.MulReset), 1);
    step();
    Reset = 1'b0;
    macc  = '{0, 0};
    movf  = '{1'b0, 1'b0};
    merr  = 1'b0;
    chk("midrst_idle", longint'(bus_a.InReady), 1);
    chk("midrst_m", longint'(bus_a.M), 0);
    chk("midrst_q", longint'(bus_a.Q), 0);
    chk("midrst_outvalid", longint'(bus_a.OutValid), 0);
    chk("midrst_err", longint'(bus_a.Err), 0);
    seen = 1'b0;
    repeat (10) begin
      step();
      if (bus_a.OutValid || !bus_a.InReady) seen = 1'b1;
    end
    chk("midrst_done_ignored", longint'(seen), 0);
    chk("midrst_data", longint'(bus_a.OutData), 0);

    // InAcc on the first operation after reset adds to zero.
    mul_lat = 2;
    do_op(4, 4, 1'b1, 0, "acc_after_reset");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
